// File: rtl/round_robin_arbiter4.sv
// round_robin_arbiter4
//   Four-way round-robin arbiter for a shared resource. An owner keeps the
//   grant while it keeps requesting, up to HOLD_MAX consecutive cycles. After
//   that the grant is forcibly released and timeout pulses for one cycle.
//   Every release passes through one zero-grant cycle. The search pointer
//   then moves to the requester after the old owner.
//
// Ports
//   clk       : system clock, rising-edge active
//   rst       : asynchronous active-high reset
//   req[3:0]  : request lines, one per requester
//   gnt[3:0]  : one-hot grant (all zero when idle)
//   gnt_idx   : binary index of the current owner (0 when idle)
//   gnt_valid : high while a grant is active
//   timeout   : one-cycle pulse after a forced release at HOLD_MAX
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate on the sampled req at each edge
// ST_GRANT | owner held; count hold cycles, release on drop or HOLD_MAX

module round_robin_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [1:0] ptr;

  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       pick_found;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // after ptr is the last one assigned, and so it wins.
  always_comb begin
    cand       = ptr;
    pick_idx   = ptr;
    pick_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= 8'd0;
      ptr       <= 2'd0;
    end else begin
      timeout <= 1'b0;
      if (state == ST_IDLE) begin
        if (pick_found) begin
          state     <= ST_GRANT;
          gnt       <= 4'b0001 << pick_idx;
          gnt_idx   <= pick_idx;
          gnt_valid <= 1'b1;
          hold_cnt  <= 8'd1;
        end
      end else begin
        if (!req[gnt_idx] || (hold_cnt == HOLD_LIMIT)) begin
          // A dropped request takes precedence: a simultaneous drop at
          // HOLD_MAX is an ordinary release with no timeout.
          timeout   <= req[gnt_idx];
          state     <= ST_IDLE;
          gnt       <= 4'b0000;
          gnt_idx   <= 2'd0;
          gnt_valid <= 1'b0;
          hold_cnt  <= 8'd0;
          ptr       <= gnt_idx + 2'd1;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// tb_round_robin_arbiter4
//   Directed checks of reset, rotation, release, timeout and async reset for
//   round_robin_arbiter4 (HOLD_MAX = 8). A random sticky-request run follows,
//   with invariant checks on every cycle.

module tb_round_robin_arbiter4;

  localparam int HOLD_MAX = 8;
  localparam int STARVE_MAX = 3 * (HOLD_MAX + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  round_robin_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_idx"}, 32'(gnt_idx), 32'h0);
    check({tag, "_valid"}, 32'(gnt_valid), 32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic check_owner(input string tag, input int owner);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << owner;
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    check({tag, "_idx"}, 32'(gnt_idx), 32'(owner));
    check({tag, "_valid"}, 32'(gnt_valid), 32'h1);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
  endtask

  initial begin
    logic [3:0] req_nxt;
    logic [3:0] req_prev;
    int         run_len;
    logic       prev_valid;
    logic [1:0] prev_idx;
    int         wait_cnt [4];
    int         max_wait;

    // Reset state
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check_idle("reset", 1'b0);
    #3 rst = 1'b0;

    // All four request: first grant goes to 0, then 1,2,3,0 with timeouts
    req = 4'b1111;
    tick();
    check_owner("first_grant", 0);
    for (int o = 0; o < 5; o++) begin
      for (int k = (o == 0) ? 1 : 0; k < HOLD_MAX; k++) begin
        if (k != 0) begin
          check("rot_hold", 32'(gnt), 32'(4'b0001 << (o % 4)));
        end else begin
          tick();
          check("rot_gnt", 32'(gnt), 32'(4'b0001 << (o % 4)));
          continue;
        end
        tick();
      end
      check("rot_last", 32'(gnt), 32'(4'b0001 << (o % 4)));
      tick();
      check_idle("rot_idle", 1'b1);
    end

    // Stay idle with no requests; the timeout pulse must be gone
    req = 4'b0000;
    tick();
    check_idle("idle_norq", 1'b0);

    // ptr is now 1. Owner 1 is not preempted by 0 and 3, and 3 wins next
    req = 4'b0010;
    tick();
    check_owner("own1", 1);
    req = 4'b1011;
    tick();
    check_owner("nopreempt_a", 1);
    tick();
    check_owner("nopreempt_b", 1);
    req = 4'b1001;
    tick();
    check_idle("rel1", 1'b0);
    tick();
    check_owner("ptr2_pick3", 3);

    // Owner 3 releases, so ptr is 0. Owner 2 holds 3 cycles, then 3 follows
    req = 4'b0100;
    tick();
    check_idle("rel3", 1'b0);
    tick();
    check_owner("own2_c1", 2);
    tick();
    check_owner("own2_c2", 2);
    tick();
    check_owner("own2_c3", 2);
    req = 4'b1000;
    tick();
    check_idle("rel2", 1'b0);
    tick();
    check_owner("own3_after2", 3);

    // Async reset mid-grant with no clock edge
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst", 1'b0);
    #1 rst = 1'b0;
    tick();
    check_owner("post_rst", 3);

    // Drop at exactly HOLD_MAX is a normal release (no timeout)
    repeat (HOLD_MAX - 1) begin
      tick();
      check("hold3", 32'(gnt), 32'h8);
    end
    req = 4'b0000;
    tick();
    check_idle("drop_at_max", 1'b0);

    // ptr is 0. Timed-out owner 0 still requests, but 1 gets priority
    req = 4'b0011;
    tick();
    check_owner("own0", 0);
    repeat (HOLD_MAX - 1) begin
      tick();
      check("hold0", 32'(gnt), 32'h1);
    end
    tick();
    check_idle("to0", 1'b1);
    tick();
    check_owner("rot_to1", 1);
    req = 4'b0000;
    tick();
    tick();
    check_idle("pre_rand", 1'b0);

    // Random sticky requests with invariant checks
    run_len    = 0;
    prev_valid = 1'b0;
    prev_idx   = 2'd0;
    max_wait   = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (gnt[i])      req_nxt[i] = ($urandom_range(3) != 0);
        else if (req[i]) req_nxt[i] = 1'b1;
        else             req_nxt[i] = ($urandom_range(2) == 0);
      end
      req      = req_nxt;
      req_prev = req_nxt;
      tick();
      check("r_onehot", 32'($onehot0(gnt)), 32'h1);
      if (gnt_valid) begin
        check("r_decode", 32'(gnt), 32'(4'b0001 << gnt_idx));
        run_len++;
        if (prev_valid) check("r_no_switch", 32'(gnt_idx), 32'(prev_idx));
      end else begin
        check("r_zero", 32'({gnt, gnt_idx}), 32'h0);
        run_len = 0;
      end
      check("r_hold", 32'(run_len <= HOLD_MAX), 32'h1);
      prev_valid = gnt_valid;
      prev_idx   = gnt_idx;
      for (int i = 0; i < 4; i++) begin
        if (req_prev[i] && !gnt[i]) wait_cnt[i]++;
        else                        wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    check("r_starve", 32'(max_wait <= STARVE_MAX), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter4.md
ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

Interface
REQ-001 Parameter: HOLD_MAX, 8, maximum consecutive grant cycles per owner before forced release (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared decoder-selected resource.
REQ-005 gnt  output 4  one-hot grant; gnt[i] high = requester i owns the resource; all-zero when none.
REQ-006 gnt_idx  output 2  binary index of current owner; 0 when gnt_valid low.
REQ-007 gnt_valid  output 1  high while any grant is active.
REQ-008 timeout  output 1  single-cycle pulse when a grant is forcibly released at HOLD_MAX.

Function
REQ-009 Two states: IDLE (no owner), GRANT (owner held); all outputs registered.
REQ-010 IDLE: req == 0 -> stay IDLE, outputs zero.
REQ-011 IDLE: req != 0 -> next edge enter GRANT; owner = first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 Grant latency: req sampled high at edge N -> gnt/gnt_idx/gnt_valid high from edge N+1.
REQ-013 gnt SHALL equal the 2-to-4 decode of gnt_idx gated by gnt_valid; never more than one bit set.
REQ-014 GRANT: hold counter starts at 1 on the entry cycle, increments by 1 each further cycle owner keeps req high.
REQ-015 GRANT: req[owner] low at an edge -> release at that edge: enter IDLE, outputs zero next cycle, ptr = owner+1 mod 4.
REQ-016 GRANT: counter == HOLD_MAX with req[owner] still high -> release at that edge, ptr = owner+1 mod 4, timeout high for exactly that next cycle.
REQ-017 Release always passes through one IDLE cycle; no back-to-back owner change without a zero-grant cycle.
REQ-018 Requests of non-owners during GRANT are ignored (no preemption); they compete at next IDLE arbitration.
REQ-019 ptr wraps 3 -> 0; ptr changes only on release.
REQ-020 Counter width 8 bits; never exceeds HOLD_MAX; cleared on every release.
REQ-021 Simultaneous owner req drop and counter == HOLD_MAX: treat as normal release, timeout stays low.
REQ-022 A timed-out owner still requesting is re-eligible at the IDLE cycle, but ptr rotation gives priority to others first.
REQ-023 req changes in IDLE between edges have no effect; only edge-sampled value matters.

Reset
REQ-024 rst high SHALL immediately force state IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, counter = 0, ptr = 0, independent of clk.
REQ-025 rst asserted during GRANT drops grant without a timeout pulse; after deassertion arbitration restarts with ptr = 0.
REQ-026 First arbitration after rst deasserts uses the first rising edge with rst low.

Verification
REQ-027 Reset, req = 4'b1111 -> after 1 edge gnt = 4'b0001, gnt_idx = 0, gnt_valid = 1.
REQ-028 req = 4'b1111 held, HOLD_MAX = 8 -> owner order 0,1,2,3,0; each grant exactly 8 cycles, timeout pulse after each, one IDLE cycle between.
REQ-029 Owner 2 holds 3 cycles then drops req[2], req[3] high -> one IDLE cycle, then gnt = 4'b1000, timeout stays 0.
REQ-030 Owner 1 active, req[0] and req[3] asserted -> no preemption; on release gnt goes to 3 (ptr = 2, search 2,3,0,1).
REQ-031 rst pulsed mid-grant of owner 3 (no clk edge) -> outputs zero immediately; after release, req = 4'b1000 -> gnt = 4'b1000 one edge later.
REQ-032 Random req stream 10k cycles -> checker: gnt one-hot or zero, gnt == decode(gnt_idx) when valid, hold <= HOLD_MAX, no requester starved beyond 3*(HOLD_MAX+1) cycles.
